// File: rtl/serial_adder_if.sv
// serial_adder_if: request/result bundle for serial_adder.
//   master : drives start, sub_mode, addend_1, addend_2, carry_in;
//            observes busy, done, sum_out, carry_out, overflow.
//   slave  : the adder side of the same signals.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);

  logic             start;
  logic             sub_mode;
  logic [WIDTH-1:0] addend_1;
  logic [WIDTH-1:0] addend_2;
  logic             carry_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum_out;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, sub_mode, addend_1, addend_2, carry_in,
    input  busy, done, sum_out, carry_out, overflow
  );

  modport slave (
    input  start, sub_mode, addend_1, addend_2, carry_in,
    output busy, done, sum_out, carry_out, overflow
  );

endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial add/subtract, one full-adder cell, LSB first.
//   sys_clk  : clock, all state on its rising edge
//   sys_rst  : synchronous active-high reset
//   io_bus   : serial_adder_if.slave
//     start/sub_mode/addend_1/addend_2/carry_in : request, captured on accept
//     busy      : high while a computation is running
//     done      : one-cycle pulse when sum_out/carry_out/overflow update
//     sum_out   : result, held until the next completion
//     carry_out : carry out of the MSB (subtract: 1 = no borrow)
//     overflow  : two's-complement overflow of the last result
// A result takes WIDTH edges after the accepting edge. The completing edge
// also accepts a new start, so back-to-back requests sustain one result
// every WIDTH cycles.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  serial_adder_if.slave  io_bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic             r_sub;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum_out;
  logic             r_carry_out;
  logic             r_overflow;

  logic             w_a;
  logic             w_b;
  logic             w_s;
  logic             w_c;
  logic             w_last;
  logic             w_accept;
  logic [WIDTH-1:0] w_acc_next;

  // Full-adder cell; subtract inverts the second operand bit on the fly.
  assign w_a        = r_op_a[0];
  assign w_b        = r_op_b[0] ^ r_sub;
  assign w_s        = w_a ^ w_b ^ r_carry;
  assign w_c        = (w_a & w_b) | ((w_a ^ w_b) & r_carry);
  assign w_last     = (r_cnt == LAST_BIT);
  assign w_acc_next = {w_s, r_acc[WIDTH-1:1]};

  // Accept in IDLE, or on the completing RUN edge for back-to-back issue.
  assign w_accept   = io_bus.start &&
                      ((r_state == ST_IDLE) || ((r_state == ST_RUN) && w_last));

  // State, datapath and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state     <= ST_IDLE;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_acc       <= '0;
      r_carry     <= 1'b0;
      r_sub       <= 1'b0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_sum_out   <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (r_state == ST_RUN) begin
        r_op_a  <= r_op_a >> 1;
        r_op_b  <= r_op_b >> 1;
        r_acc   <= w_acc_next;
        r_carry <= w_c;
        if (w_last) begin
          // r_carry here is the carry into the MSB.
          r_sum_out   <= w_acc_next;
          r_carry_out <= w_c;
          r_overflow  <= r_carry ^ w_c;
          r_done      <= 1'b1;
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      // Later assignments override the shift/return above on accept.
      if (w_accept) begin
        r_op_a  <= io_bus.addend_1;
        r_op_b  <= io_bus.addend_2;
        r_sub   <= io_bus.sub_mode;
        r_carry <= io_bus.sub_mode ? 1'b1 : io_bus.carry_in;
        r_acc   <= '0;
        r_cnt   <= '0;
        r_state <= ST_RUN;
        r_busy  <= 1'b1;
      end
    end
  end

  assign io_bus.busy      = r_busy;
  assign io_bus.done      = r_done;
  assign io_bus.sum_out   = r_sum_out;
  assign io_bus.carry_out = r_carry_out;
  assign io_bus.overflow  = r_overflow;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vectors for serial_adder at WIDTH=8.
module tb_serial_adder;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  serial_adder_if #(.WIDTH(8)) bus ();

  serial_adder #(.WIDTH(8)) u_dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .io_bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request; returns the number of edges from accept to done.
  task automatic run_op(input logic sub, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, output int lat);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.sub_mode = sub;
    bus.addend_1 = a;
    bus.addend_2 = b;
    bus.carry_in = cin;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.addend_1 = ~a;
    bus.addend_2 = ~b;
    bus.sub_mode = ~sub;
    bus.carry_in = ~cin;
    check("busy_rise", 32'(bus.busy), 32'd1);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic vec(input string tag, input logic sub, input logic [7:0] a,
                     input logic [7:0] b, input logic cin, input logic [7:0] e_sum,
                     input logic e_cout, input logic e_ovf);
    int lat;
    run_op(sub, a, b, cin, lat);
    check({tag, "_lat"},  32'(lat), 32'd8);
    check({tag, "_sum"},  32'(bus.sum_out), 32'(e_sum));
    check({tag, "_cout"}, 32'(bus.carry_out), 32'(e_cout));
    check({tag, "_ovf"},  32'(bus.overflow), 32'(e_ovf));
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    check({tag, "_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_hold"},  32'(bus.sum_out), 32'(e_sum));
  endtask

  initial begin
    int lat;
    int e;
    int e1;
    int e2;
    int n_done;
    logic [7:0] s1;
    logic [7:0] s2;
    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.sub_mode = 1'b0;
    bus.addend_1 = 8'h00;
    bus.addend_2 = 8'h00;
    bus.carry_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_sum",  32'(bus.sum_out), 32'd0);
    check("rst_cout", 32'(bus.carry_out), 32'd0);
    check("rst_ovf",  32'(bus.overflow), 32'd0);

    // start together with reset is ignored
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk); #1;
    rst       = 1'b0;
    bus.start = 1'b0;
    check("rst_start_busy", 32'(bus.busy), 32'd0);

    vec("add_wrap", 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    vec("add_ovf",  1'b0, 8'h7F, 8'h01, 1'b1, 8'h81, 1'b0, 1'b1);
    vec("sub_brw",  1'b1, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    vec("sub_nobrw",1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);
    vec("add_cin",  1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);

    // start while busy is ignored
    @(negedge clk);
    bus.start = 1'b1; bus.sub_mode = 1'b0; bus.addend_1 = 8'h10; bus.addend_2 = 8'h20; bus.carry_in = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.sub_mode = 1'b1; bus.addend_1 = 8'hAA; bus.addend_2 = 8'h55; bus.carry_in = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    e = 3; n_done = 0; e1 = 0; s1 = 8'h00;
    while (e < 24) begin
      @(posedge clk); #1;
      e++;
      if (bus.done === 1'b1) begin
        n_done++;
        e1 = e;
        s1 = bus.sum_out;
      end
    end
    check("busy_ign_ndone", 32'(n_done), 32'd1);
    check("busy_ign_lat",   32'(e1), 32'd8);
    check("busy_ign_sum",   32'(s1), 32'h30);
    check("busy_ign_idle",  32'(bus.busy), 32'd0);

    // back-to-back: start held high across the completing edge
    @(negedge clk);
    bus.start = 1'b1; bus.sub_mode = 1'b0; bus.addend_1 = 8'h01; bus.addend_2 = 8'h02; bus.carry_in = 1'b0;
    @(posedge clk); #1;
    bus.addend_1 = 8'h03; bus.addend_2 = 8'h04;
    e = 0; e1 = 0; e2 = 0; s1 = 8'h00; s2 = 8'h00;
    while (e < 30 && e2 == 0) begin
      @(posedge clk); #1;
      e++;
      if (bus.done === 1'b1) begin
        if (e1 == 0) begin
          e1 = e;
          s1 = bus.sum_out;
          check("b2b_busy_kept", 32'(bus.busy), 32'd1);
          bus.start = 1'b0;
        end else begin
          e2 = e;
          s2 = bus.sum_out;
        end
      end
    end
    bus.start = 1'b0;
    check("b2b_first_lat", 32'(e1), 32'd8);
    check("b2b_first_sum", 32'(s1), 32'h03);
    check("b2b_gap",       32'(e2 - e1), 32'd8);
    check("b2b_second_sum",32'(s2), 32'h07);

    // reset while bit 4 is being processed
    @(negedge clk);
    bus.start = 1'b1; bus.sub_mode = 1'b0; bus.addend_1 = 8'h55; bus.addend_2 = 8'h33; bus.carry_in = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    check("mid_rst_sum",  32'(bus.sum_out), 32'd0);
    check("mid_rst_cout", 32'(bus.carry_out), 32'd0);
    check("mid_rst_ovf",  32'(bus.overflow), 32'd0);
    n_done = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) n_done++;
    end
    check("mid_rst_nodone", 32'(n_done), 32'd0);
    check("mid_rst_sum_kept", 32'(bus.sum_out), 32'd0);
    vec("post_rst", 1'b0, 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8: operand and result width in bits; legal range 2..32.
REQ-002 sys_clk  input  1  single clock; all state SHALL change only on its rising edge.
REQ-003 sys_rst  input  1  reset; SHALL be synchronous and active-high.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 sub_mode  input  1  operation select; 0 = add, 1 = subtract; captured with start.
REQ-006 addend_1  input  WIDTH  first operand; captured with start.
REQ-007 addend_2  input  WIDTH  second operand; captured with start.
REQ-008 carry_in  input  1  carry into bit 0 in add mode; captured with start.
REQ-009 busy  output  1  high while a computation is in progress.
REQ-010 done  output  1  single-cycle pulse when the result is valid.
REQ-011 sum_out  output  WIDTH  result; held until the next result.
REQ-012 carry_out  output  1  carry out of the MSB; in subtract mode, 1 means no borrow.
REQ-013 overflow  output  1  two's-complement signed overflow of the last result.

Function
REQ-014 The FSM SHALL have two states: IDLE and RUN.
REQ-015 IDLE with start=1 SHALL, on that edge, load the operand shift registers and clear the bit counter.
REQ-016 That same edge SHALL latch sub_mode and enter RUN.
REQ-017 On entry to RUN, the carry register SHALL be carry_in in add mode and 1 in subtract mode.
REQ-018 Subtract mode SHALL use ~addend_2 as the second operand, so the result equals addend_1 - addend_2 mod 2^WIDTH; carry_in is ignored.
REQ-019 Each RUN edge SHALL process exactly one bit, LSB first, using one full-adder cell: s = a ^ b ^ c, c' = (a & b) | ((a ^ b) & c).
REQ-020 Each RUN edge SHALL shift s into the result register and store c' in the carry register.
REQ-021 The bit counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL count 0..WIDTH-1 with no wrap beyond WIDTH-1.
REQ-022 On the RUN edge that processes bit WIDTH-1, the block SHALL return to IDLE.
REQ-023 On that same edge, sum_out, carry_out and overflow SHALL update; overflow = carry into MSB XOR carry out of MSB.
REQ-024 On that same edge, done SHALL be set for exactly one cycle.
REQ-025 Latency SHALL be fixed: start sampled at edge T0 gives busy=1 for cycles T0+1..T0+WIDTH and done=1 in the cycle after edge T0+WIDTH.
REQ-026 busy SHALL equal (state == RUN).
REQ-027 start while busy=1 SHALL be ignored, with no effect on operands, mode or result.
REQ-028 start asserted in the same cycle as done SHALL be accepted, giving back-to-back operation with throughput of one result per WIDTH cycles.
REQ-029 sum_out, carry_out and overflow SHALL change only when a result completes; they are not disturbed by a new start.
REQ-030 Operand and mode inputs SHALL be don't-care except on the edge where start is accepted.

Reset
REQ-031 sys_rst=1 SHALL, on the next rising edge and with priority over all other inputs, force state IDLE and clear the counter, carry and shift registers.
REQ-032 That reset edge SHALL also force busy=0, done=0, sum_out=0, carry_out=0 and overflow=0.
REQ-033 Reset during RUN SHALL abort the operation, with no done pulse and no partial result on sum_out.
REQ-034 start asserted together with sys_rst SHALL be ignored.

Verification (WIDTH=8)
REQ-035 Add wrap: add 0xFF + 0x01, carry_in=0 -> done 8 cycles after busy rises; sum_out=0x00, carry_out=1, overflow=0.
REQ-036 Signed overflow: add 0x7F + 0x01, carry_in=1 -> sum_out=0x81, carry_out=0, overflow=1.
REQ-037 Subtract with borrow: sub 0x05 - 0x07, carry_in=1 -> sum_out=0xFE, carry_out=0, overflow=0.
REQ-038 Subtract, no borrow: 0x80 - 0x01 -> sum_out=0x7F, carry_out=1, overflow=1.
REQ-039 Start while busy: during RUN of 0x10+0x20, start with 0xAA+0x55 -> ignored; result 0x30; exactly one done pulse.
REQ-040 Back-to-back: start held high across the done cycle -> second result done exactly 8 cycles after the first.
REQ-041 Reset mid-RUN: sys_rst pulsed at bit 4 -> all outputs 0, no done; a following 0x03+0x04 gives 0x07.
